// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write side.
// Holds the skid-buffer state encoding and Gray decode.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // Gray to binary; callers zero-extend and truncate.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchronizer bringing the Gray read pointer
// into the write clock domain.
module sync_r2w #(
    parameter int ADDRSIZE = 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   wq2_rptr
);

    logic [ADDRSIZE:0] r_q1;
    logic [ADDRSIZE:0] r_q2;

    // Plain two-stage flop chain, nothing between stages.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= rptr;
            r_q2 <= r_q1;
        end
    end

    assign wq2_rptr = r_q2;

endmodule

// File: rtl/wr_flow_ctrl.sv
// Write-side flow control: 2-entry skid buffer feeding
// the FIFO, plus fill level, almost-full and error flag.
module wr_flow_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE  = 4,
    parameter int DSIZE     = 8,
    parameter int AF_THRESH = (1 << ADDRSIZE) - 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid,
    input  logic [DSIZE-1:0]    s_data,
    output logic                s_ready,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic                wfull,
    output logic                winc,
    output logic [DSIZE-1:0]    wdata,
    output logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic                werr
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] LP_AF  = PW'(AF_THRESH);
    localparam logic [ADDRSIZE:0] LP_MAX = PW'(1 << ADDRSIZE);

    skid_state_e       r_state;
    skid_state_e       w_nstate;
    logic [DSIZE-1:0]  r_buf0;
    logic [DSIZE-1:0]  r_buf1;
    logic [DSIZE-1:0]  w_nbuf0;
    logic [DSIZE-1:0]  w_nbuf1;
    logic              r_ready;
    logic              r_af;
    logic              r_err;
    logic              w_push;
    logic              w_pop;
    logic [ADDRSIZE:0] w_wbin;
    logic [ADDRSIZE:0] w_rbin;

    sync_r2w #(
        .ADDRSIZE (ADDRSIZE)
    ) u_sync (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .rptr     (rptr),
        .wq2_rptr (wq2_rptr)
    );

    assign w_wbin = PW'(gray2bin(32'(wptr)));
    assign w_rbin = PW'(gray2bin(32'(wq2_rptr)));
    assign wlevel = w_wbin - w_rbin;

    assign w_push = s_valid & r_ready;
    assign w_pop  = (r_state != EMPTY) & ~wfull;

    assign winc    = w_pop;
    assign wdata   = r_buf0;
    assign s_ready = r_ready;

    assign walmost_full = r_af;
    assign werr         = r_err;

    // Skid next state; buf0 is always the oldest word.
    always_comb begin
        w_nstate = r_state;
        w_nbuf0  = r_buf0;
        w_nbuf1  = r_buf1;
        unique case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_nstate = ONE;
                    w_nbuf0  = s_data;
                end
            end
            ONE: begin
                if (w_push && w_pop) begin
                    w_nbuf0 = s_data;
                end else if (w_push) begin
                    w_nstate = TWO;
                    w_nbuf1  = s_data;
                end else if (w_pop) begin
                    w_nstate = EMPTY;
                end
            end
            TWO: begin
                if (w_pop) begin
                    w_nstate = ONE;
                    w_nbuf0  = r_buf1;
                end
            end
            default: begin
                w_nstate = EMPTY;
            end
        endcase
    end

    // Skid state, storage and registered ready.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state <= EMPTY;
            r_buf0  <= '0;
            r_buf1  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_buf0  <= w_nbuf0;
            r_buf1  <= w_nbuf1;
            r_ready <= (w_nstate != TWO);
        end
    end

    // Almost-full flag and sticky level-corruption flag.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_af  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_af <= (wlevel >= LP_AF);
            if (wlevel > LP_MAX) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wr_flow_ctrl.sv
// Directed bench for wr_flow_ctrl: skid flow, stall,
// level/almost-full/error and reset behaviour.
module tb_wr_flow_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_ready;
    logic [4:0] rptr = '0;
    logic [4:0] wptr = '0;
    logic       wfull = 1'b0;
    logic       winc;
    logic [7:0] wdata;
    logic [4:0] wq2_rptr;
    logic [4:0] wlevel;
    logic       walmost_full;
    logic       werr;

    int pass = 0;
    int tot  = 0;

    always #5 wclk = ~wclk;

    wr_flow_ctrl #(
        .ADDRSIZE  (4),
        .DSIZE     (8),
        .AF_THRESH (14)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .rptr         (rptr),
        .wptr         (wptr),
        .wfull        (wfull),
        .winc         (winc),
        .wdata        (wdata),
        .wq2_rptr     (wq2_rptr),
        .wlevel       (wlevel),
        .walmost_full (walmost_full),
        .werr         (werr)
    );

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    task automatic test_reset();
        wrst_n  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        wfull   = 1'b0;
        wptr    = '0;
        rptr    = '0;
        @(negedge wclk);
        @(negedge wclk);
        tot++; if (s_ready !== 1'b0) $display("FAIL rst_ready got=%0b exp=0", s_ready); else pass++;
        tot++; if (winc !== 1'b0) $display("FAIL rst_winc got=%0b exp=0", winc); else pass++;
        tot++; if (wdata !== 8'h00) $display("FAIL rst_wdata got=%h exp=00", wdata); else pass++;
        tot++; if (wq2_rptr !== 5'd0) $display("FAIL rst_wq2 got=%0d exp=0", wq2_rptr); else pass++;
        tot++; if (walmost_full !== 1'b0) $display("FAIL rst_af got=%0b exp=0", walmost_full); else pass++;
        tot++; if (werr !== 1'b0) $display("FAIL rst_err got=%0b exp=0", werr); else pass++;
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        tot++; if (s_ready !== 1'b1) $display("FAIL rst_rel_ready got=%0b exp=1", s_ready); else pass++;
        @(negedge wclk);
    endtask

    task automatic test_back_to_back();
        s_valid = 1'b1;
        s_data  = 8'hA1;
        @(negedge wclk);
        tot++; if (winc !== 1'b1) $display("FAIL b2b_winc1 got=%0b exp=1", winc); else pass++;
        tot++; if (wdata !== 8'hA1) $display("FAIL b2b_data1 got=%h exp=a1", wdata); else pass++;
        tot++; if (s_ready !== 1'b1) $display("FAIL b2b_ready1 got=%0b exp=1", s_ready); else pass++;
        s_data = 8'hB2;
        @(negedge wclk);
        tot++; if (winc !== 1'b1) $display("FAIL b2b_winc2 got=%0b exp=1", winc); else pass++;
        tot++; if (wdata !== 8'hB2) $display("FAIL b2b_data2 got=%h exp=b2", wdata); else pass++;
        tot++; if (s_ready !== 1'b1) $display("FAIL b2b_ready2 got=%0b exp=1", s_ready); else pass++;
        s_valid = 1'b0;
        @(negedge wclk);
        tot++; if (winc !== 1'b0) $display("FAIL b2b_idle got=%0b exp=0", winc); else pass++;
    endtask

    task automatic test_stall();
        wfull   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA1;
        @(negedge wclk);
        tot++; if (s_ready !== 1'b1) $display("FAIL stall_ready1 got=%0b exp=1", s_ready); else pass++;
        s_data = 8'hB2;
        @(negedge wclk);
        tot++; if (s_ready !== 1'b0) $display("FAIL stall_ready2 got=%0b exp=0", s_ready); else pass++;
        s_data = 8'hC3;
        @(negedge wclk);
        tot++; if (s_ready !== 1'b0) $display("FAIL stall_ready3 got=%0b exp=0", s_ready); else pass++;
        tot++; if (winc !== 1'b0) $display("FAIL stall_winc got=%0b exp=0", winc); else pass++;
        tot++; if (wdata !== 8'hA1) $display("FAIL stall_hold got=%h exp=a1", wdata); else pass++;
        s_valid = 1'b0;
        wfull   = 1'b0;
        #1;
        tot++; if (winc !== 1'b1) $display("FAIL stall_rel_winc got=%0b exp=1", winc); else pass++;
        tot++; if (wdata !== 8'hA1) $display("FAIL stall_rel_d1 got=%h exp=a1", wdata); else pass++;
        @(negedge wclk);
        tot++; if (winc !== 1'b1) $display("FAIL stall_winc2 got=%0b exp=1", winc); else pass++;
        tot++; if (wdata !== 8'hB2) $display("FAIL stall_rel_d2 got=%h exp=b2", wdata); else pass++;
        tot++; if (s_ready !== 1'b1) $display("FAIL stall_ready_back got=%0b exp=1", s_ready); else pass++;
        @(negedge wclk);
        tot++; if (winc !== 1'b0) $display("FAIL stall_drain got=%0b exp=0", winc); else pass++;
    endtask

    task automatic test_almost_full();
        wptr = gray(13);
        rptr = gray(0);
        @(negedge wclk);
        tot++; if (wlevel !== 5'd13) $display("FAIL af_lvl13 got=%0d exp=13", wlevel); else pass++;
        tot++; if (walmost_full !== 1'b0) $display("FAIL af_at13 got=%0b exp=0", walmost_full); else pass++;
        wptr = gray(14);
        #1;
        tot++; if (walmost_full !== 1'b0) $display("FAIL af_not_yet got=%0b exp=0", walmost_full); else pass++;
        @(negedge wclk);
        @(negedge wclk);
        tot++; if (wq2_rptr !== 5'd0) $display("FAIL af_wq2 got=%0d exp=0", wq2_rptr); else pass++;
        tot++; if (wlevel !== 5'd14) $display("FAIL af_lvl14 got=%0d exp=14", wlevel); else pass++;
        @(negedge wclk);
        tot++; if (walmost_full !== 1'b1) $display("FAIL af_set got=%0b exp=1", walmost_full); else pass++;
    endtask

    task automatic test_wrap();
        wptr = gray(16);
        rptr = gray(0);
        @(negedge wclk);
        @(negedge wclk);
        tot++; if (wlevel !== 5'd16) $display("FAIL full_lvl got=%0d exp=16", wlevel); else pass++;
        tot++; if (werr !== 1'b0) $display("FAIL full_err got=%0b exp=0", werr); else pass++;
        wptr = gray(2);
        rptr = gray(30);
        @(negedge wclk);
        tot++; if (wlevel !== 5'd2) $display("FAIL wrap_mid got=%0d exp=2", wlevel); else pass++;
        @(negedge wclk);
        tot++; if (wq2_rptr !== gray(30)) $display("FAIL wrap_wq2 got=%0d exp=%0d", wq2_rptr, gray(30)); else pass++;
        tot++; if (wlevel !== 5'd4) $display("FAIL wrap_lvl got=%0d exp=4", wlevel); else pass++;
        @(negedge wclk);
        tot++; if (werr !== 1'b0) $display("FAIL wrap_err got=%0b exp=0", werr); else pass++;
        tot++; if (walmost_full !== 1'b0) $display("FAIL wrap_af got=%0b exp=0", walmost_full); else pass++;
    endtask

    task automatic test_err();
        wptr = gray(20);
        rptr = gray(0);
        @(negedge wclk);
        @(negedge wclk);
        tot++; if (wlevel !== 5'd20) $display("FAIL err_lvl got=%0d exp=20", wlevel); else pass++;
        @(negedge wclk);
        tot++; if (werr !== 1'b1) $display("FAIL err_set got=%0b exp=1", werr); else pass++;
        rptr = gray(20);
        @(negedge wclk);
        @(negedge wclk);
        @(negedge wclk);
        tot++; if (wlevel !== 5'd0) $display("FAIL err_lvl0 got=%0d exp=0", wlevel); else pass++;
        tot++; if (werr !== 1'b1) $display("FAIL err_sticky got=%0b exp=1", werr); else pass++;
    endtask

    task automatic test_reset_mid();
        wptr    = '0;
        rptr    = '0;
        wfull   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hC3;
        @(negedge wclk);
        s_data = 8'hD4;
        @(negedge wclk);
        tot++; if (s_ready !== 1'b0) $display("FAIL mid_two got=%0b exp=0", s_ready); else pass++;
        wrst_n  = 1'b0;
        wfull   = 1'b0;
        s_valid = 1'b0;
        #1;
        tot++; if (winc !== 1'b0) $display("FAIL mid_winc got=%0b exp=0", winc); else pass++;
        tot++; if (s_ready !== 1'b0) $display("FAIL mid_ready got=%0b exp=0", s_ready); else pass++;
        tot++; if (wdata !== 8'h00) $display("FAIL mid_wdata got=%h exp=00", wdata); else pass++;
        @(negedge wclk);
        wrst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge wclk);
            tot++; if (winc !== 1'b0) $display("FAIL mid_stale%0d got=%0b exp=0", i, winc); else pass++;
        end
        tot++; if (s_ready !== 1'b1) $display("FAIL mid_ready_back got=%0b exp=1", s_ready); else pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_almost_full();
        test_reset();
        test_wrap();
        test_err();
        test_reset();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end

endmodule

// File: doc/wr_flow_ctrl.md
WR_FLOW_CTRL -- requirements
Module: wr_flow_ctrl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, FIFO address width; depth = 2^ADDRSIZE.
REQ-002 SHALL have parameter DSIZE, default 8, data word width.
REQ-003 SHALL have parameter AF_THRESH, default 2^ADDRSIZE-2, almost-full fill level.
REQ-004 SHALL have port wclk  in  1  write-domain clock.
REQ-005 SHALL have port wrst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_valid  in  1  upstream word valid.
REQ-007 SHALL have port s_data  in  DSIZE  upstream word.
REQ-008 SHALL have port s_ready  out  1  upstream may transfer; transfer = s_valid & s_ready at a rising wclk edge.
REQ-009 SHALL have port rptr  in  ADDRSIZE+1  Gray read pointer, asynchronous to wclk.
REQ-010 SHALL have port wptr  in  ADDRSIZE+1  Gray write pointer from the write-pointer/full block.
REQ-011 SHALL have port wfull  in  1  FIFO full flag, registered in the write domain.
REQ-012 SHALL have port winc  out  1  FIFO write strobe.
REQ-013 SHALL have port wdata  out  DSIZE  FIFO write data, valid when winc=1.
REQ-014 SHALL have port wq2_rptr  out  ADDRSIZE+1  rptr synchronized into wclk.
REQ-015 SHALL have port wlevel  out  ADDRSIZE+1  FIFO fill level seen from the write side.
REQ-016 SHALL have port walmost_full  out  1  registered, wlevel >= AF_THRESH.
REQ-017 SHALL have port werr  out  1  sticky level-corruption flag.

Function
REQ-018 SHALL pass rptr through two wclk flops to wq2_rptr; no other logic between the stages.
REQ-019 SHALL convert wptr and wq2_rptr Gray->binary and compute wlevel = wbin - rbin modulo 2^(ADDRSIZE+1), combinationally.
REQ-020 SHALL buffer upstream words in a 2-entry skid buffer with states EMPTY, ONE, TWO.
REQ-021 SHALL drive winc = (state != EMPTY) & ~wfull, with wdata = oldest buffered word.
REQ-022 SHALL register s_ready: next value is 1 when the next state is EMPTY or ONE, 0 when it is TWO.
REQ-023 SHALL make these transitions: EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; TWO->ONE on pop. A simultaneous push and pop holds the state.
REQ-024 SHALL give a word accepted at edge n an earliest winc assertion in cycle n+1, i.e. one-cycle latency.
REQ-025 SHALL preserve word order; no word is dropped or duplicated, including when push and pop occur in the same cycle.
REQ-026 SHALL hold wdata and the buffer contents stable while wfull=1, with winc=0.
REQ-027 SHALL register walmost_full from the comparison wlevel >= AF_THRESH.
REQ-028 SHALL set werr when wlevel > 2^ADDRSIZE; werr stays set until reset.
REQ-029 SHALL handle pointer wrap: wlevel stays correct across the MSB wrap of either pointer.

Reset
REQ-030 SHALL, while wrst_n=0, force: state EMPTY, s_ready 0, winc 0, wdata 0, both synchronizer stages 0, walmost_full 0, werr 0.
REQ-031 SHALL assert s_ready on the first wclk edge after wrst_n deasserts.
REQ-032 SHALL discard buffered words when reset asserts mid-operation.

Structure
REQ-033 SHALL place a gray2bin function and the skid-state enum (EMPTY/ONE/TWO) in shared package fifo_pkg.
REQ-034 SHALL instantiate the synchronizer as sub-module sync_r2w, parameterized by ADDRSIZE.

Verification
REQ-035 SHALL cover this scenario: after reset, push 0xA1, 0xB2 on consecutive cycles with wfull=0 -> winc in cycles 1 and 2 with wdata A1 then B2; s_ready stays 1.
REQ-036 SHALL cover this scenario: wfull=1 held, push 3 words -> 2 accepted, s_ready=0 from the edge after the second; release wfull -> A1, B2 written in order, s_ready returns to 1.
REQ-037 SHALL cover this scenario: wptr=Gray(14), rptr=Gray(0), AF_THRESH=14 -> after 2 clocks wq2_rptr=0, wlevel=14, walmost_full=1 one clock later.
REQ-038 SHALL cover this scenario: wptr=Gray(2), rptr=Gray(30) (wrap) -> wlevel=4 and werr=0.
REQ-039 SHALL cover this scenario: wptr=Gray(20), rptr=Gray(0) -> wlevel=20, werr=1, and werr stays 1 after rptr=Gray(20).
REQ-040 SHALL cover this scenario: reset asserted while in TWO -> winc=0 and s_ready=0 immediately; after release, no stale word is written.
